bram_tdp_be_init: RTL and testbench

BRAM_TDP_BE_INIT -- requirements
Module: bram_tdp_be_init

---
 rtl/bram_tdp_be_init.sv | 179 +++++++++++++++++
 tb/tb_bram_tdp_be_init.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/bram_tdp_be_init.sv
// True dual-port block RAM with per-byte write enables, a power-up init sweep
// that fills every word with INIT_VALUE, and selectable same-port
// read-during-write behaviour plus an optional output register.

// Per-port read pipeline: stage entry is decided combinationally from the
// accepted access, then 1 (OUT_REG=0) or 2 (OUT_REG=1) registered stages.
module bram_tdp_be_init_port #(
    parameter int DATA_WIDTH = 32,
    parameter int RDW_MODE   = 0,
    parameter int OUT_REG    = 0
) (
    input  logic                  clockIn,
    input  logic                  resetIn,
    input  logic                  acc_i,
    input  logic                  wr_i,
    input  logic [DATA_WIDTH-1:0] old_i,
    input  logic [DATA_WIDTH-1:0] merged_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o
);
    localparam int STAGES = (OUT_REG != 0) ? 2 : 1;

    logic                             vld0;
    logic [DATA_WIDTH-1:0]            dat0;
    logic [STAGES-1:0]                vld_q;
    logic [STAGES-1:0][DATA_WIDTH-1:0] dat_q;
    logic [STAGES:0]                  vld_pipe;
    logic [STAGES:0][DATA_WIDTH-1:0]  dat_pipe;

    // Stage entry: reads always produce data; writes produce data unless no-change
    always_comb begin
        vld0 = acc_i && !(wr_i && (RDW_MODE == 2));
        dat0 = (wr_i && (RDW_MODE == 0)) ? merged_i : old_i;
    end

    assign vld_pipe = {vld_q, vld0};
    assign dat_pipe = {dat_q, dat0};

    // Shift valid bits every cycle; data only moves with a valid so it holds otherwise
    always_ff @(posedge clockIn) begin
        if (resetIn) begin
            vld_q <= '0;
            dat_q <= '0;
        end else begin
            vld_q <= vld_pipe[STAGES-1:0];
            for (int s = 0; s < STAGES; s++) begin
                if (vld_pipe[s]) dat_q[s] <= dat_pipe[s];
            end
        end
    end

    assign data_o  = dat_pipe[STAGES];
    assign valid_o = vld_pipe[STAGES];
endmodule

module bram_tdp_be_init #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    BYTE_WIDTH = 8,
    parameter int                    RDW_MODE   = 0,
    parameter int                    OUT_REG    = 0,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                             clockIn,
    input  logic                             resetIn,
    output logic                             initBusyOut,
    input  logic                             enIn_a,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] wrEnIn_a,
    input  logic [ADDR_WIDTH-1:0]            addrIn_a,
    input  logic [DATA_WIDTH-1:0]            dataIn_a,
    output logic [DATA_WIDTH-1:0]            dataOut_a,
    output logic                             validOut_a,
    input  logic                             enIn_b,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] wrEnIn_b,
    input  logic [ADDR_WIDTH-1:0]            addrIn_b,
    input  logic [DATA_WIDTH-1:0]            dataIn_b,
    output logic [DATA_WIDTH-1:0]            dataOut_b,
    output logic                             validOut_b
);
    localparam int NB       = DATA_WIDTH / BYTE_WIDTH;
    localparam int MEM_SIZE = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] LAST_ADDR = (ADDR_WIDTH+1)'(MEM_SIZE - 1);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH:0]   initCnt_q, initCnt_d;
    logic                  sweepWr;
    logic                  run;
    logic [ADDR_WIDTH-1:0] sweepAddr;

    logic [DATA_WIDTH-1:0] mem [MEM_SIZE];

    // Ports gathered into packed per-port buses; index 0 = A, 1 = B
    logic [1:0]                       acc, wr, en;
    logic [1:0][NB-1:0]               we;
    logic [1:0][ADDR_WIDTH-1:0]       addr;
    logic [1:0][DATA_WIDTH-1:0]       din, old, mrg, dout;
    logic [1:0]                       vout;

    // Controller state register; reset restarts the sweep from address 0
    always_ff @(posedge clockIn) begin
        if (resetIn) begin
            state_q   <= ST_INIT;
            initCnt_q <= '0;
        end else begin
            state_q   <= state_d;
            initCnt_q <= initCnt_d;
        end
    end

    // Next state: step the sweep address, leave INIT after the last word
    always_comb begin
        state_d   = state_q;
        initCnt_d = initCnt_q;
        if (state_q == ST_INIT) begin
            initCnt_d = initCnt_q + 1'b1;
            if (initCnt_q == LAST_ADDR) state_d = ST_RUN;
        end
    end

    // Controller outputs: busy flag, sweep write strobe, port gating
    always_comb begin
        initBusyOut = (state_q == ST_INIT);
        sweepWr     = (state_q == ST_INIT) && !resetIn;
        run         = (state_q == ST_RUN) && !resetIn;
        sweepAddr   = initCnt_q[ADDR_WIDTH-1:0];
    end

    assign en   = {enIn_b, enIn_a};
    assign we   = {wrEnIn_b, wrEnIn_a};
    assign addr = {addrIn_b, addrIn_a};
    assign din  = {dataIn_b, dataIn_a};

    generate
        for (genvar p = 0; p < 2; p++) begin : g_port
            assign acc[p] = en[p] && run;
            assign wr[p]  = |we[p];
            assign old[p] = mem[addr[p]];

            for (genvar l = 0; l < NB; l++) begin : g_lane
                assign mrg[p][l*BYTE_WIDTH +: BYTE_WIDTH] = we[p][l] ?
                    din[p][l*BYTE_WIDTH +: BYTE_WIDTH] : old[p][l*BYTE_WIDTH +: BYTE_WIDTH];
            end

            bram_tdp_be_init_port #(
                .DATA_WIDTH (DATA_WIDTH),
                .RDW_MODE   (RDW_MODE),
                .OUT_REG    (OUT_REG)
            ) u_port (
                .clockIn  (clockIn),
                .resetIn  (resetIn),
                .acc_i    (acc[p]),
                .wr_i     (wr[p]),
                .old_i    (old[p]),
                .merged_i (mrg[p]),
                .data_o   (dout[p]),
                .valid_o  (vout[p])
            );
        end
    endgenerate

    // Array writes: sweep in INIT, per-lane port writes in RUN.
    // B is issued before A so A wins any lane both ports enable on one word.
    always_ff @(posedge clockIn) begin
        if (sweepWr) mem[sweepAddr] <= INIT_VALUE;
        for (int l = 0; l < NB; l++) begin
            if (acc[1] && we[1][l])
                mem[addr[1]][l*BYTE_WIDTH +: BYTE_WIDTH] <= din[1][l*BYTE_WIDTH +: BYTE_WIDTH];
            if (acc[0] && we[0][l])
                mem[addr[0]][l*BYTE_WIDTH +: BYTE_WIDTH] <= din[0][l*BYTE_WIDTH +: BYTE_WIDTH];
        end
    end

    assign dataOut_a  = dout[0];
    assign validOut_a = vout[0];
    assign dataOut_b  = dout[1];
    assign validOut_b = vout[1];
endmodule

// File: tb/tb_bram_tdp_be_init.sv
// Bench for bram_tdp_be_init: three instances (write-first/no outreg,
// read-first/outreg, no-change/no outreg) share one stimulus stream and are
// compared every cycle against a word-level memory model.
module tb_bram_tdp_be_init;
    localparam int ND = 3;
    localparam logic [31:0] IV = 32'hA5A5A5A5;

    logic        clockIn = 1'b0;
    logic        resetIn;
    logic        enA, enB;
    logic [3:0]  weA, weB, adA, adB;
    logic [31:0] diA, diB;

    logic        bsy [ND];
    logic [31:0] doa [ND], dob [ND];
    logic        voa [ND], vob [ND];

    generate
        for (genvar g = 0; g < ND; g++) begin : g_dut
            bram_tdp_be_init #(
                .DATA_WIDTH (32), .ADDR_WIDTH (4), .BYTE_WIDTH (8),
                .RDW_MODE (g), .OUT_REG ((g == 1) ? 1 : 0), .INIT_VALUE (IV)
            ) u_dut (
                .clockIn (clockIn), .resetIn (resetIn), .initBusyOut (bsy[g]),
                .enIn_a (enA), .wrEnIn_a (weA), .addrIn_a (adA), .dataIn_a (diA),
                .dataOut_a (doa[g]), .validOut_a (voa[g]),
                .enIn_b (enB), .wrEnIn_b (weB), .addrIn_b (adB), .dataIn_b (diB),
                .dataOut_b (dob[g]), .validOut_b (vob[g])
            );
        end
    endgenerate

    initial forever #5 clockIn = ~clockIn;

    // Reference model state
    int          lat [ND] = '{1, 2, 1};
    logic [31:0] m [16];
    bit          mbusy;
    int          mcnt;
    logic [31:0] ed [ND][2];
    bit          ev [ND][2];
    logic [31:0] pd [ND][2];
    bit          pv [ND][2];
    int          nerr = 0, nchk = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] lmerge(input logic [31:0] o, input logic [31:0] n,
                                           input logic [3:0] w);
        for (int l = 0; l < 4; l++) if (w[l]) o[8*l +: 8] = n[8*l +: 8];
        return o;
    endfunction

    // Apply one clock edge's worth of behaviour to the model
    task automatic model_edge();
        logic [31:0] rd [ND][2];
        bit          rv [ND][2];
        bit          en [2];
        logic [3:0]  we [2], ad [2];
        logic [31:0] di [2], old, od;
        bit          ov;
        en[0] = enA; en[1] = enB; we[0] = weA; we[1] = weB;
        ad[0] = adA; ad[1] = adB; di[0] = diA; di[1] = diB;
        if (resetIn) begin
            mbusy = 1; mcnt = 0;
            for (int d = 0; d < ND; d++)
                for (int p = 0; p < 2; p++) begin
                    ed[d][p] = '0; ev[d][p] = 0; pd[d][p] = '0; pv[d][p] = 0;
                end
            return;
        end
        for (int d = 0; d < ND; d++)
            for (int p = 0; p < 2; p++) begin rd[d][p] = '0; rv[d][p] = 0; end
        if (mbusy) begin
            m[mcnt] = IV;
            mcnt++;
            if (mcnt == 16) mbusy = 0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (!en[p]) continue;
                old = m[ad[p]];
                for (int d = 0; d < ND; d++) begin
                    if (we[p] == 4'h0)  begin rv[d][p] = 1; rd[d][p] = old; end
                    else if (d == 0)    begin rv[d][p] = 1; rd[d][p] = lmerge(old, di[p], we[p]); end
                    else if (d == 1)    begin rv[d][p] = 1; rd[d][p] = old; end
                end
            end
            // port A applied last: its lanes win on a shared word
            if (en[1]) m[ad[1]] = lmerge(m[ad[1]], di[1], we[1]);
            if (en[0]) m[ad[0]] = lmerge(m[ad[0]], di[0], we[0]);
        end
        for (int d = 0; d < ND; d++)
            for (int p = 0; p < 2; p++) begin
                if (lat[d] == 2) begin
                    ov = pv[d][p]; od = pd[d][p]; pv[d][p] = rv[d][p]; pd[d][p] = rd[d][p];
                end else begin
                    ov = rv[d][p]; od = rd[d][p];
                end
                ev[d][p] = ov;
                if (ov) ed[d][p] = od;
            end
    endtask

    task automatic cyc();
        model_edge();
        @(posedge clockIn);
        @(negedge clockIn);
        for (int d = 0; d < ND; d++) begin
            chk($sformatf("dut%0d busy", d), 32'(bsy[d]), 32'(mbusy));
            chk($sformatf("dut%0d dataA", d), doa[d], ed[d][0]);
            chk($sformatf("dut%0d validA", d), 32'(voa[d]), 32'(ev[d][0]));
            chk($sformatf("dut%0d dataB", d), dob[d], ed[d][1]);
            chk($sformatf("dut%0d validB", d), 32'(vob[d]), 32'(ev[d][1]));
        end
    endtask

    task automatic op(input bit ea, input logic [3:0] wa, input logic [3:0] aa, input logic [31:0] da,
                      input bit eb, input logic [3:0] wb, input logic [3:0] ab, input logic [31:0] db);
        enA = ea; weA = wa; adA = aa; diA = da;
        enB = eb; weB = wb; adB = ab; diB = db;
        cyc();
    endtask

    task automatic idle();
        op(0, 4'h0, 4'h0, 32'h0, 0, 4'h0, 4'h0, 32'h0);
    endtask

    initial begin
        int n;
        resetIn = 1'b1;
        idle();
        idle();
        chk("reset_busy", 32'(bsy[0]), 32'd1);
        chk("reset_dataB", dob[1], 32'h0);

        // Sweep with both ports hammering: nothing may be accepted
        resetIn = 1'b0;
        enA = 1; weA = 4'hF; adA = 4'd2; diA = 32'hDEADBEEF;
        enB = 1; weB = 4'hF; adB = 4'd9; diB = 32'h12121212;
        n = 0;
        while (bsy[0] === 1'b1 && n < 40) begin n++; cyc(); end
        chk("sweep_len", 32'(n), 32'd16);

        for (int a = 0; a < 16; a++) begin
            op(0, 4'h0, 4'h0, 32'h0, 1, 4'h0, 4'(a), 32'h0);
            chk("sweep_rd", dob[0], IV);
            chk("sweep_rd_v", 32'(vob[0]), 32'd1);
        end

        // Byte enables and latency
        op(1, 4'hF, 4'd3, 32'h11223344, 0, 4'h0, 4'd0, 32'h0);
        op(1, 4'b0101, 4'd3, 32'hFFFFFFFF, 0, 4'h0, 4'd0, 32'h0);
        op(0, 4'h0, 4'd0, 32'h0, 1, 4'h0, 4'd3, 32'h0);
        chk("be_rd_l1", dob[0], 32'h11FF33FF);
        chk("be_v_l2_early", 32'(vob[1]), 32'd0);
        idle();
        chk("be_rd_l2", dob[1], 32'h11FF33FF);
        chk("be_v_l2", 32'(vob[1]), 32'd1);

        // Same-port read-during-write
        op(1, 4'hF, 4'd5, 32'h0, 0, 4'h0, 4'd0, 32'h0);
        idle();
        op(1, 4'hF, 4'd5, 32'hCAFE0001, 0, 4'h0, 4'd0, 32'h0);
        chk("rdw_wf_d", doa[0], 32'hCAFE0001);
        chk("rdw_wf_v", 32'(voa[0]), 32'd1);
        chk("rdw_nc_d", doa[2], 32'h0);
        chk("rdw_nc_v", 32'(voa[2]), 32'd0);
        idle();
        chk("rdw_rf_d", doa[1], 32'h0);
        chk("rdw_rf_v", 32'(voa[1]), 32'd1);

        // Write/write collision and cross-port read-during-write
        op(1, 4'hF, 4'd7, 32'h0, 0, 4'h0, 4'd0, 32'h0);
        op(1, 4'b0011, 4'd7, 32'hAAAAAAAA, 1, 4'b0110, 4'd7, 32'hBBBBBBBB);
        op(0, 4'h0, 4'd0, 32'h0, 1, 4'h0, 4'd7, 32'h0);
        chk("coll_word", dob[0], 32'h00BBAAAA);
        op(1, 4'hF, 4'd9, 32'h0, 0, 4'h0, 4'd0, 32'h0);
        op(1, 4'hF, 4'd9, 32'h12345678, 1, 4'h0, 4'd9, 32'h0);
        chk("cross_old", dob[0], 32'h0);
        op(1, 4'hF, 4'd15, 32'h0F0F0F0F, 1, 4'h0, 4'd9, 32'h0);
        chk("cross_new", dob[0], 32'h12345678);
        op(0, 4'h0, 4'd0, 32'h0, 1, 4'h0, 4'd15, 32'h0);
        chk("top_addr", dob[0], 32'h0F0F0F0F);

        // Random traffic on a narrow address range to force collisions
        repeat (300)
            op(1'($urandom), 4'($urandom), 4'($urandom_range(0, 3)), $urandom,
               1'($urandom), 4'($urandom), 4'($urandom_range(0, 3)), $urandom);

        // Reset with a read in flight on the registered-output instance
        op(0, 4'h0, 4'd0, 32'h0, 1, 4'h0, 4'd0, 32'h0);
        resetIn = 1'b1;
        idle();
        chk("inflight_drop", 32'(vob[1]), 32'd0);
        idle();
        resetIn = 1'b0;

        // Reset in the middle of the sweep, ports held enabled throughout
        enA = 1; weA = 4'hF; adA = 4'd1; diA = 32'h55555555;
        enB = 1; weB = 4'h0; adB = 4'd1; diB = 32'h0;
        repeat (9) cyc();
        resetIn = 1'b1;
        cyc();
        cyc();
        chk("midsweep_busy", 32'(bsy[2]), 32'd1);
        resetIn = 1'b0;
        n = 0;
        while (bsy[0] === 1'b1 && n < 40) begin n++; cyc(); end
        chk("resweep_len", 32'(n), 32'd16);
        for (int a = 0; a < 16; a++) begin
            op(1, 4'h0, 4'(15 - a), 32'h0, 1, 4'h0, 4'(a), 32'h0);
            chk("resweep_rd", dob[2], IV);
        end
        idle();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
